// File: rtl/frame_pixel_packer_if.sv
// Stream interfaces around the pixel packer: the renderer's pixel stream in,
// and the tagged 128-bit word stream out to the DRAM writer.
interface pix_stream_if;
    logic [8:0]  pix_h;
    logic [7:0]  pix_v;
    logic        pix_valid;
    logic        pix_last;
    logic [15:0] pix_data;

    modport master (output pix_h, pix_v, pix_valid, pix_last, pix_data);
    modport slave  (input  pix_h, pix_v, pix_valid, pix_last, pix_data);
endinterface

interface word_stream_if #(
    parameter int ADDR_WIDTH = 16
);
    logic [127:0]          word_data;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  word_last;
    logic                  word_valid;
    logic                  word_ready;

    modport master (output word_data, word_addr, word_last, word_valid, input  word_ready);
    modport slave  (input  word_data, word_addr, word_last, word_valid, output word_ready);
endinterface

// File: rtl/frame_pixel_packer.sv
// Packs 8 RGB565 pixels per 128-bit framebuffer word, buffers words in a
// first-word-fall-through FIFO and ping-pongs between two framebuffers.
module frame_pixel_packer #(
    parameter int H_RES      = 320,
    parameter int V_RES      = 180,
    parameter int FIFO_DEPTH = 64,
    parameter int ADDR_WIDTH = 16,
    parameter int FB_BASE0   = 0,
    parameter int FB_BASE1   = 7200
) (
    input  logic                        clk,
    input  logic                        rst,
    pix_stream_if.slave                 pix,
    word_stream_if.master               word,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        frame_select,
    output logic                        display_buffer,
    output logic                        frame_done,
    output logic                        overflow,
    output logic                        misalign
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 128 + ADDR_WIDTH + 2;
    localparam logic [ADDR_WIDTH-1:0] BASE0 = ADDR_WIDTH'(FB_BASE0);
    localparam logic [ADDR_WIDTH-1:0] BASE1 = ADDR_WIDTH'(FB_BASE1);

    // packer state
    logic [2:0]            exp_q, exp_d;
    logic [7:0][15:0]      lanes_q, lanes_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  frame_select_q, misalign_q;
    logic                  push_q, push_d;
    logic [127:0]          push_data_q;
    logic [ADDR_WIDTH-1:0] push_addr_q;
    logic                  push_last_q, push_buf_q;

    // FIFO state
    logic [EW-1:0]         fifo_mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, frame_done_q, display_buffer_q;

    logic [2:0]            lane;
    logic                  in_range, accept, match, start, write, drop;
    logic [ADDR_WIDTH-1:0] line_offset, addr_calc;
    logic                  fifo_full, word_valid, do_pop, do_push;
    logic [127:0]          head_data;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic                  head_last, head_buf;

    genvar gi;

    // Out-of-raster coordinates are ignored rather than corrupting a word.
    assign lane     = pix.pix_h[2:0];
    assign in_range = (32'(pix.pix_h) < 32'(H_RES)) && (32'(pix.pix_v) < 32'(V_RES));
    assign accept   = pix.pix_valid && in_range;
    assign match    = (lane == exp_q);
    assign start    = accept && (lane == 3'd0);
    assign write    = accept && (match || start);
    assign drop     = accept && !write;

    generate
        if (H_RES == 320) begin : g_line_shift
            assign line_offset = (ADDR_WIDTH'(pix.pix_v) << 5) + (ADDR_WIDTH'(pix.pix_v) << 3);
        end else begin : g_line_mul
            assign line_offset = ADDR_WIDTH'(pix.pix_v) * ADDR_WIDTH'(H_RES / 8);
        end
    endgenerate

    assign addr_calc = (frame_select_q ? BASE1 : BASE0) + line_offset + ADDR_WIDTH'(pix.pix_h[8:3]);
    assign addr_d    = start ? addr_calc : addr_q;

    // A lane-0 pixel always opens a fresh word, so stale upper lanes are zeroed.
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            assign lanes_d[gi] = drop                           ? 16'h0 :
                                 (write && lane == 3'(gi))      ? pix.pix_data :
                                 start                          ? 16'h0 : lanes_q[gi];
        end
    endgenerate

    always_comb begin
        exp_d  = exp_q;
        push_d = 1'b0;
        if (accept) begin
            if (pix.pix_last) begin
                exp_d  = 3'd0;
                push_d = 1'b1;
            end else if (write) begin
                exp_d  = lane + 3'd1;
                push_d = (lane == 3'd7);
            end else begin
                exp_d  = 3'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q          <= 3'd0;
            lanes_q        <= '0;
            addr_q         <= '0;
            frame_select_q <= 1'b0;
            misalign_q     <= 1'b0;
            push_q         <= 1'b0;
            push_data_q    <= '0;
            push_addr_q    <= '0;
            push_last_q    <= 1'b0;
            push_buf_q     <= 1'b0;
        end else begin
            exp_q          <= exp_d;
            lanes_q        <= lanes_d;
            addr_q         <= addr_d;
            frame_select_q <= frame_select_q ^ (accept && pix.pix_last);
            misalign_q     <= misalign_q | (accept && !match);
            push_q         <= push_d;
            if (push_d) begin
                push_data_q <= lanes_d;
                push_addr_q <= addr_d;
                push_last_q <= pix.pix_last;
                push_buf_q  <= frame_select_q;
            end
        end
    end

    // A pop frees a slot in the same cycle, so push-while-full is honoured then.
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign word_valid = (count_q != '0);
    assign do_pop     = word_valid && word.word_ready;
    assign do_push    = push_q && (!fifo_full || do_pop);

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem_q[wr_ptr_q] <= {push_buf_q, push_last_q, push_addr_q, push_data_q};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            overflow_q       <= 1'b0;
            frame_done_q     <= 1'b0;
            display_buffer_q <= 1'b1;
        end else begin
            count_q      <= count_d;
            overflow_q   <= overflow_q | (push_q && !do_push);
            frame_done_q <= do_pop && head_last;
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
                if (head_last) begin
                    display_buffer_q <= head_buf;
                end
            end
        end
    end

    // Head entry is read combinationally so the word is presented without a bubble.
    assign {head_buf, head_last, head_addr, head_data} = fifo_mem_q[rd_ptr_q];

    assign word.word_valid = word_valid;
    assign word.word_data  = word_valid ? head_data : '0;
    assign word.word_addr  = word_valid ? head_addr : '0;
    assign word.word_last  = word_valid && head_last;

    assign fifo_count     = count_q;
    assign frame_select   = frame_select_q;
    assign display_buffer = display_buffer_q;
    assign frame_done     = frame_done_q;
    assign overflow       = overflow_q;
    assign misalign       = misalign_q;
endmodule

// File: tb/tb_frame_pixel_packer.sv
// Directed bench for frame_pixel_packer: line packing, full frame ping-pong,
// backpressure/overflow, misalignment, full-FIFO push+pop and mid-word reset.
module tb_frame_pixel_packer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pix_stream_if                      pix_if ();
    word_stream_if #(.ADDR_WIDTH(16))  word_if ();

    logic [6:0] fifo_count;
    logic       frame_select, display_buffer, frame_done, overflow, misalign;

    frame_pixel_packer #(
        .H_RES(320), .V_RES(180), .FIFO_DEPTH(64), .ADDR_WIDTH(16),
        .FB_BASE0(0), .FB_BASE1(7200)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pix            (pix_if),
        .word           (word_if),
        .fifo_count     (fifo_count),
        .frame_select   (frame_select),
        .display_buffer (display_buffer),
        .frame_done     (frame_done),
        .overflow       (overflow),
        .misalign       (misalign)
    );

    int checks = 0;
    int errors = 0;

    logic [127:0] cap_data [$];
    logic [15:0]  cap_addr [$];
    logic         cap_last [$];
    int           fd_total = 0;

    // Record every handshaken word and every frame_done pulse.
    always @(negedge clk) begin
        if (!rst && word_if.word_valid && word_if.word_ready) begin
            cap_data.push_back(word_if.word_data);
            cap_addr.push_back(word_if.word_addr);
            cap_last.push_back(word_if.word_last);
        end
        if (!rst && frame_done) fd_total++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%032h expected=%032h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] seq_word(input int first);
        logic [127:0] w;
        for (int k = 0; k < 8; k++) w[16*k +: 16] = 16'(first + k);
        return w;
    endfunction

    task automatic send(input int h, input int v, input int data, input logic last);
        pix_if.pix_valid = 1'b1;
        pix_if.pix_h     = 9'(h);
        pix_if.pix_v     = 8'(v);
        pix_if.pix_data  = 16'(data);
        pix_if.pix_last  = last;
        @(posedge clk); #1;
        pix_if.pix_valid = 1'b0;
        pix_if.pix_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        word_if.word_ready = 1'b1;
        for (int i = 0; i < budget && word_if.word_valid; i++) @(negedge clk);
        check_int("drain_done", int'(word_if.word_valid), 0);
    endtask

    initial begin
        int base;
        int fd0;

        pix_if.pix_valid   = 1'b0;
        pix_if.pix_last    = 1'b0;
        pix_if.pix_h       = '0;
        pix_if.pix_v       = '0;
        pix_if.pix_data    = '0;
        word_if.word_ready = 1'b0;
        rst = 1'b1;

        // reset state
        idle(3);
        @(negedge clk);
        check_int("rst_word_valid", int'(word_if.word_valid), 0);
        check_int("rst_fifo_count", int'(fifo_count), 0);
        check_int("rst_frame_select", int'(frame_select), 0);
        check_int("rst_display_buffer", int'(display_buffer), 1);
        check_int("rst_frame_done", int'(frame_done), 0);
        check_int("rst_overflow", int'(overflow), 0);
        check_int("rst_misalign", int'(misalign), 0);
        check_word("rst_word_data", word_if.word_data, 128'h0);
        check_int("rst_word_addr", int'(word_if.word_addr), 0);
        rst = 1'b0;
        $display("step reset done");

        // one line, v = 0
        word_if.word_ready = 1'b1;
        base = cap_addr.size();
        for (int h = 0; h < 320; h++) send(h, 0, h, 1'b0);
        idle(6);
        @(negedge clk);
        check_int("line_words", cap_addr.size() - base, 40);
        for (int n = 0; n < 40; n++) begin
            check_int("line_addr", int'(cap_addr[base+n]), n);
            check_word("line_data", cap_data[base+n], seq_word(8*n));
        end
        check_int("line_overflow", int'(overflow), 0);
        check_int("line_misalign", int'(misalign), 0);
        $display("step single line: %0d words", cap_addr.size() - base);

        // full frame into buffer 0
        base = cap_addr.size();
        fd0  = fd_total;
        for (int v = 0; v < 180; v++)
            for (int h = 0; h < 320; h++)
                send(h, v, v*320 + h, (v == 179 && h == 319));
        idle(6);
        @(negedge clk);
        check_int("frame_words", cap_addr.size() - base, 7200);
        check_int("frame_first_addr", int'(cap_addr[base]), 0);
        check_int("frame_final_addr", int'(cap_addr[base+7199]), 7199);
        check_int("frame_final_last", int'(cap_last[base+7199]), 1);
        check_int("frame_prev_last", int'(cap_last[base+7198]), 0);
        check_word("frame_final_data", cap_data[base+7199], seq_word(179*320 + 312));
        check_int("frame_done_pulses", fd_total - fd0, 1);
        check_int("frame_display_buffer", int'(display_buffer), 0);
        check_int("frame_select_after", int'(frame_select), 1);
        check_int("frame_misalign", int'(misalign), 0);
        $display("step full frame: %0d words", cap_addr.size() - base);

        // first word of next frame lands in buffer 1
        base = cap_addr.size();
        for (int h = 0; h < 8; h++) send(h, 0, h, 1'b0);
        idle(6);
        @(negedge clk);
        check_int("next_words", cap_addr.size() - base, 1);
        check_int("next_addr", int'(cap_addr[base]), 7200);
        check_int("next_last", int'(cap_last[base]), 0);
        $display("step next frame first word");

        // backpressure: 70 words against a 64-deep FIFO
        word_if.word_ready = 1'b0;
        base = cap_addr.size();
        for (int p = 0; p < 560; p++) send(p % 320, p / 320, p, 1'b0);
        idle(4);
        @(negedge clk);
        check_int("bp_fifo_count", int'(fifo_count), 64);
        check_int("bp_overflow", int'(overflow), 1);
        check_int("bp_head_addr", int'(word_if.word_addr), 7200);
        drain(200);
        check_int("bp_drained", cap_addr.size() - base, 64);
        for (int n = 0; n < 64; n++) begin
            check_int("bp_addr", int'(cap_addr[base+n]), 7200 + n);
            check_word("bp_data", cap_data[base+n], seq_word(8*n));
        end
        $display("step backpressure: %0d words drained", cap_addr.size() - base);

        // misalignment on v = 2, plus empty-FIFO latency
        rst = 1'b1;
        idle(2);
        @(negedge clk);
        rst = 1'b0;
        word_if.word_ready = 1'b0;
        base = cap_addr.size();
        for (int h = 0; h < 4; h++) send(h, 2, 100 + h, 1'b0);
        for (int h = 8; h < 15; h++) send(h, 2, 200 + h, 1'b0);
        send(15, 2, 215, 1'b0);
        @(negedge clk);
        check_int("mis_latency_1", int'(word_if.word_valid), 0);
        @(negedge clk);
        check_int("mis_latency_2", int'(word_if.word_valid), 1);
        check_int("mis_fifo_count", int'(fifo_count), 1);
        check_int("mis_addr", int'(word_if.word_addr), 81);
        check_word("mis_data", word_if.word_data, seq_word(208));
        check_int("mis_flag", int'(misalign), 1);
        word_if.word_ready = 1'b1;
        idle(3);
        @(negedge clk);
        check_int("mis_words", cap_addr.size() - base, 1);
        check_int("mis_overflow", int'(overflow), 0);
        $display("step misalign: %0d words", cap_addr.size() - base);

        // full FIFO with simultaneous push and pop
        word_if.word_ready = 1'b0;
        base = cap_addr.size();
        for (int h = 0; h < 320; h++) send(h, 3, 960 + h, 1'b0);
        for (int h = 0; h < 192; h++) send(h, 4, 1280 + h, 1'b0);
        idle(4);
        @(negedge clk);
        check_int("full_fifo_count", int'(fifo_count), 64);
        check_int("full_overflow_pre", int'(overflow), 0);
        for (int h = 192; h < 199; h++) send(h, 4, 1280 + h, 1'b0);
        send(199, 4, 1479, 1'b0);
        word_if.word_ready = 1'b1;
        @(posedge clk); #1;
        word_if.word_ready = 1'b0;
        @(negedge clk);
        check_int("full_pp_count", int'(fifo_count), 64);
        check_int("full_pp_overflow", int'(overflow), 0);
        check_int("full_pp_head_addr", int'(word_if.word_addr), 121);
        check_word("full_pp_head_data", word_if.word_data, seq_word(968));
        drain(200);
        check_int("full_drained", cap_addr.size() - base, 65);
        check_int("full_first_addr", int'(cap_addr[base]), 120);
        check_int("full_tail_addr", int'(cap_addr[base+64]), 184);
        check_word("full_tail_data", cap_data[base+64], seq_word(1472));
        $display("step full fifo push+pop: %0d words", cap_addr.size() - base);

        // close a frame, then reset in the middle of a word
        word_if.word_ready = 1'b1;
        send(0, 0, 7, 1'b1);
        idle(6);
        @(negedge clk);
        check_int("pre_rst_frame_select", int'(frame_select), 1);
        check_int("pre_rst_display_buffer", int'(display_buffer), 0);
        for (int h = 0; h < 5; h++) send(h, 0, 900 + h, 1'b0);
        rst = 1'b1;
        idle(2);
        @(negedge clk);
        rst = 1'b0;
        base = cap_addr.size();
        check_int("rst_mid_frame_select", int'(frame_select), 0);
        check_int("rst_mid_display_buffer", int'(display_buffer), 1);
        for (int h = 0; h < 320; h++) send(h, 0, 50 + h, 1'b0);
        idle(6);
        @(negedge clk);
        check_int("rst_mid_words", cap_addr.size() - base, 40);
        check_int("rst_mid_first_addr", int'(cap_addr[base]), 0);
        check_word("rst_mid_first_data", cap_data[base], seq_word(50));
        check_int("rst_mid_last_addr", int'(cap_addr[base+39]), 39);
        check_int("rst_mid_misalign", int'(misalign), 0);
        check_int("rst_mid_display_after", int'(display_buffer), 1);
        $display("step reset mid-word: %0d words", cap_addr.size() - base);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/frame_pixel_packer.md
Name: frame_pixel_packer

Overview:
- Sits directly downstream of the tile renderer. It consumes the renderer's pixel stream (h, v, valid, last, 16-bit colour) and packs 8 consecutive pixels into 128-bit words.
- Each word is tagged with a framebuffer word address and the words are buffered in a FIFO. They drain to the DRAM write interface over a valid/ready handshake.
- The renderer cannot stall, so this block absorbs backpressure and ping-pongs between two framebuffers, reporting which buffer is complete for display.

Parameters:
- H_RES, 320, pixels per line.
- V_RES, 180, lines per frame.
- FIFO_DEPTH, 64, word FIFO entries; power of two.
- ADDR_WIDTH, 16, word address width.
- FB_BASE0, 0, word base address of framebuffer 0.
- FB_BASE1, 7200, word base address of framebuffer 1 (H_RES*V_RES/8).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- pix_h  in  9  pixel column, 0..H_RES-1.
- pix_v  in  8  pixel row, 0..V_RES-1.
- pix_valid  in  1  pixel qualifier; no backpressure.
- pix_last  in  1  final pixel of frame; qualified by pix_valid.
- pix_data  in  16  RGB565 colour.
- word_data  out  128  packed pixels; lane k at bits [16k+15:16k], lane = pix_h[2:0].
- word_addr  out  ADDR_WIDTH  framebuffer word address.
- word_last  out  1  word holds the frame's last pixel.
- word_valid  out  1  FIFO non-empty.
- word_ready  in  1  sink accepts the word when asserted with word_valid.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- frame_select  out  1  buffer currently being written.
- display_buffer  out  1  most recently completed buffer.
- frame_done  out  1  one-cycle pulse on handshake of a word_last word.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.
- misalign  out  1  sticky: a partial word was discarded.

Behaviour:
- Reset values:
  - All outputs 0, except display_buffer = 1.
  - FIFO emptied; packer lane counter = 0; partial word discarded.
  - Reset mid-operation discards everything in flight; no word is emitted after rst.
- Packer accepts a pixel on every pix_valid cycle. Expected lane counter `exp` runs 0..7.
- Pixel with pix_h[2:0] == exp:
  - Its data is written to lane exp and exp increments.
  - At lane 0, address is latched as base + pix_v*40 + pix_h[8:3]. Base is FB_BASE0 when frame_select = 0, else FB_BASE1.
  - Address arithmetic uses full ADDR_WIDTH; pix_v*40 is computed as (v<<5)+(v<<3).
- Pixel with pix_h[2:0] != exp:
  - Partial word is discarded and misalign is set.
  - If pix_h[2:0] == 0, the pixel starts a new word; otherwise packer waits for the next lane-0 pixel with exp = 0.
- Lane-7 accept completes the word. It is pushed into the FIFO on the following cycle, so a word is visible on word_valid 2 cycles after its lane-7 pixel when the FIFO was empty.
- pix_last accept:
  - Current word is pushed even if incomplete (lanes beyond exp = 0), with word_last = 1.
  - exp resets to 0 and frame_select toggles in the same cycle.
  - Pixels after that use the new base.
- FIFO behaviour:
  - First-word-fall-through: word_data, word_addr and word_last reflect the head entry while word_valid = 1.
  - Pop on word_valid && word_ready.
  - Push and pop in the same cycle are both honoured, including when full; this is not an overflow.
  - Push when full without a pop drops the incoming word and sets overflow; FIFO contents are unchanged.
- Pop of a word with word_last = 1: frame_done pulses the next cycle and display_buffer takes the buffer of that word, which is the value of frame_select before its toggle.
- Sticky flags clear only on rst.
- fifo_count updates one cycle after each push or pop.

Test Plan:
- One line v = 0, h = 0..319, pix_data = h, word_ready = 1 -> 40 words at addresses 0..39; word n lane k = 8n+k; overflow = misalign = 0.
- Full frame (57600 pixels) with pix_last on (319, 179), ready = 1 ->
  - 7200 words; final word at address 7199 with word_last = 1.
  - frame_done pulses once; display_buffer = 0; frame_select = 1.
  - Next frame's first word is at address 7200.
- word_ready = 0 while 70 words are produced -> fifo_count saturates at 64 and overflow = 1. After releasing ready, exactly the first 64 words drain, in order, with correct addresses.
- Pixels h = 0..3 then h = 8..15 on v = 2 -> misalign = 1; no word for h 0..3; one word at address 81 with lanes = data of h 8..15.
- FIFO full with word_ready = 1 and a push in the same cycle -> fifo_count stays 64 and overflow stays 0.
- rst asserted after 5 pixels of a word, then a fresh line -> no stale word emitted; first word is at address 0 with display_buffer = 1.
